// File: rtl/mvm_arbiter_if.sv
// Request/grant/engine handshake bundle shared by the requesters, the engine and mvm_arbiter.
// The master modport is the requester/engine side; the slave modport is the arbiter.
interface mvm_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               busy;
    logic               eng_start;
    logic               eng_done;
    logic [NUM_REQ-1:0] done;
    logic               error;

    modport master (
        output req,
        output eng_done,
        input  grant,
        input  grant_idx,
        input  busy,
        input  eng_start,
        input  done,
        input  error
    );

    modport slave (
        input  req,
        input  eng_done,
        output grant,
        output grant_idx,
        output busy,
        output eng_start,
        output done,
        output error
    );
endinterface

// File: rtl/mvm_arbiter.sv
// Round-robin arbiter that hands one matrix-vector engine to NUM_REQ requesters, one job at a time.
// Define MVM_ARB_TIMEOUT_EN to build the BUSY watchdog (sticky error, forced completion).
module mvm_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int IDX_W          = 2,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMER_W        = 8
) (
    input  logic         clk,
    input  logic         reset,
    mvm_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [NUM_REQ-1:0] done_q;
    logic               eng_start_q;
    logic               busy_q;

    logic               found;
    logic [IDX_W-1:0]   win_idx_d;
    logic [NUM_REQ-1:0] win_grant_d;
    logic [IDX_W-1:0]   ptr_next_d;

`ifdef MVM_ARB_TIMEOUT_EN
    logic [TIMER_W-1:0] timer_q;
    logic               error_q;
`endif

    // Elaboration-time guard: an illegal parameter set produces this marker block.
    if (((2 ** IDX_W) < NUM_REQ) || (TIMER_W < 1) || (TIMEOUT_CYCLES < 1)) begin : g_illegal_params
    end

    // Round-robin pick: first search from ptr upward, then wrap around to the low indices.
    always_comb begin
        found       = 1'b0;
        win_idx_d   = '0;
        win_grant_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && bus.req[i] && (i >= int'(ptr_q))) begin
                found          = 1'b1;
                win_idx_d      = IDX_W'(i);
                win_grant_d[i] = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && bus.req[i]) begin
                found          = 1'b1;
                win_idx_d      = IDX_W'(i);
                win_grant_d[i] = 1'b1;
            end
        end
    end

    assign ptr_next_d = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;

    // Job sequencer; every output is a register written alongside the state change that implies it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            idx_q       <= '0;
            ptr_q       <= '0;
            done_q      <= '0;
            eng_start_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef MVM_ARB_TIMEOUT_EN
            timer_q     <= '0;
            error_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (|bus.req) begin
                        grant_q     <= win_grant_d;
                        idx_q       <= win_idx_d;
                        eng_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= START;
                    end
                end
                START: begin
                    eng_start_q <= 1'b0;
`ifdef MVM_ARB_TIMEOUT_EN
                    timer_q     <= '0;
`endif
                    state_q     <= BUSY;
                end
                BUSY: begin
                    if (bus.eng_done) begin
                        done_q  <= grant_q;
                        state_q <= DONE;
                    end
`ifdef MVM_ARB_TIMEOUT_EN
                    else if (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                        error_q <= 1'b1;
                        done_q  <= grant_q;
                        state_q <= DONE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
`endif
                end
                DONE: begin
                    done_q  <= '0;
                    grant_q <= '0;
                    idx_q   <= '0;
                    ptr_q   <= ptr_next_d;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.grant     = grant_q;
    assign bus.grant_idx = idx_q;
    assign bus.busy      = busy_q;
    assign bus.eng_start = eng_start_q;
    assign bus.done      = done_q;
`ifdef MVM_ARB_TIMEOUT_EN
    assign bus.error     = error_q;
`else
    assign bus.error     = 1'b0;
`endif

endmodule

// File: tb/tb_mvm_arbiter.sv
// Randomized scoreboard bench for mvm_arbiter: the driver queues expected grants/completions
// from a round-robin reference model, and a negedge monitor pops and compares them.
module tb_mvm_arbiter;

    localparam int N = 4;
`ifdef MVM_ARB_TIMEOUT_EN
    localparam int TMO = 10;
`else
    localparam int TMO = 255;
`endif

    typedef struct {
        logic [N-1:0] onehot;
        int           idx;
        int           due;
        logic         errExp;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cycle = 0;
    int   passCount = 0;
    int   checkCount = 0;
    int   ptrModel = 0;
    logic errModel = 1'b0;
    bit   reqHeld = 1'b0;
    exp_t startQ[$];
    exp_t doneQ[$];
    exp_t monEntry;

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    mvm_arbiter_if #(.NUM_REQ(N), .IDX_W(2)) bus ();

    mvm_arbiter #(
        .NUM_REQ(N),
        .IDX_W(2),
        .TIMEOUT_CYCLES(TMO),
        .TIMER_W(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cycle);
    endtask

    // Reference rule: scan upward from the pointer, wrapping, and take the first requester.
    function automatic int pickWinner(input logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            if (r[(ptrModel + k) % N]) return (ptrModel + k) % N;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.eng_start) begin
                if (startQ.size() == 0) checkOutput("unexpected_eng_start", 1, 0);
                else begin
                    monEntry = startQ.pop_front();
                    checkOutput("start_grant", bus.grant, monEntry.onehot);
                    checkOutput("start_grant_idx", bus.grant_idx, monEntry.idx);
                    checkOutput("start_latency", cycle, monEntry.due);
                    checkOutput("start_busy", bus.busy, 1);
                end
            end
            if (bus.done != '0) begin
                if (doneQ.size() == 0) checkOutput("unexpected_done", bus.done, 0);
                else begin
                    monEntry = doneQ.pop_front();
                    checkOutput("done_vector", bus.done, monEntry.onehot);
                    checkOutput("done_latency", cycle, monEntry.due);
                    checkOutput("done_grant_stable", bus.grant, monEntry.onehot);
                    checkOutput("done_idx_stable", bus.grant_idx, monEntry.idx);
                    checkOutput("done_error", bus.error, monEntry.errExp);
                end
            end
        end
    end

    task automatic waitEngStart(output bit ok);
        int waitCnt = 0;
        while (!bus.eng_start && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        ok = bus.eng_start;
        if (!ok) checkOutput("eng_start_timeout", 0, 1);
    endtask

    // One engine job; keepReq leaves req asserted through DONE so the next call chains directly.
    task automatic applyStimulus(input logic [N-1:0] r, input int delay, input bit extraDone, input bit keepReq);
        int   w;
        bit   ok;
        exp_t e;
        if (reqHeld) begin
            bus.req = r;
            e.due   = cycle + 2;
        end else begin
            @(negedge clk);
            bus.req = r;
            e.due   = cycle + 1;
        end
        reqHeld  = 1'b0;
        w        = pickWinner(r);
        e.onehot = N'(1) << w;
        e.idx    = w;
        e.errExp = errModel;
        startQ.push_back(e);
        waitEngStart(ok);
        if (!ok) begin
            bus.req = '0;
            return;
        end
        repeat (delay) @(negedge clk);
        bus.eng_done = 1'b1;
        e.due = cycle + 1;
        doneQ.push_back(e);
        @(negedge clk);
        ptrModel = (w + 1) % N;
        if (extraDone || !keepReq) bus.req = '0;
        if (extraDone) @(negedge clk);
        bus.eng_done = 1'b0;
        if (keepReq && !extraDone) reqHeld = 1'b1;
    endtask

    task automatic releaseHeld();
        if (reqHeld) begin
            bus.req = '0;
            reqHeld = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic pulseReset();
        @(negedge clk);
        reset = 1'b1;
        bus.req = '0;
        bus.eng_done = 1'b0;
        #1;
        checkOutput("reset_grant", bus.grant, 0);
        checkOutput("reset_grant_idx", bus.grant_idx, 0);
        checkOutput("reset_busy", bus.busy, 0);
        checkOutput("reset_eng_start", bus.eng_start, 0);
        checkOutput("reset_done", bus.done, 0);
        checkOutput("reset_error", bus.error, 0);
        @(negedge clk);
        reset = 1'b0;
        ptrModel = 0;
        errModel = 1'b0;
        reqHeld = 1'b0;
        startQ.delete();
        doneQ.delete();
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin
        bit   ok;
        exp_t e;
        reset = 1'b1;
        bus.req = '0;
        bus.eng_done = 1'b0;
        repeat (2) @(negedge clk);
        pulseReset();

        // Continuous full contention must rotate 0,1,2,3,0,1,2,3.
        for (int k = 0; k < 8; k++) begin
            applyStimulus(4'b1111, $urandom_range(1, 4), 1'b0, (k != 7));
            checkOutput("rotation_ptr", ptrModel, (k + 1) % N);
        end
        releaseHeld();

        applyStimulus(4'b0100, 5, 1'b0, 1'b0);
        applyStimulus(4'b1000, 2, 1'b0, 1'b0);
        applyStimulus(4'b1001, 3, 1'b0, 1'b0);

        // Engine completion strobe with nobody owning the engine must be ignored.
        @(negedge clk);
        bus.eng_done = 1'b1;
        @(negedge clk);
        bus.eng_done = 1'b0;
        checkOutput("idle_spurious_busy", bus.busy, 0);
        checkOutput("idle_spurious_eng_start", bus.eng_start, 0);
        @(negedge clk);
        checkOutput("idle_spurious_done", bus.done, 0);

        applyStimulus(4'b0010, 2, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("done_spurious_busy", bus.busy, 0);

        for (int k = 0; k < 30; k++) begin
            applyStimulus(N'($urandom_range(1, 15)), $urandom_range(1, 6),
                          ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1);
        end
        releaseHeld();

        // Abandon a job owned by requester 1 in BUSY; no done may follow and arbitration restarts at 0.
        @(negedge clk);
        bus.req = 4'b0010;
        e.onehot = 4'b0010;
        e.idx = 1;
        e.due = cycle + 1;
        e.errExp = 1'b0;
        startQ.push_back(e);
        waitEngStart(ok);
        repeat (3) @(negedge clk);
        checkOutput("pre_reset_grant_idx", bus.grant_idx, 1);
        pulseReset();
        applyStimulus(4'b1111, 2, 1'b0, 1'b0);
        checkOutput("post_reset_ptr", ptrModel, 1);

`ifdef MVM_ARB_TIMEOUT_EN
        // Withheld eng_done: watchdog finishes the job after TMO BUSY cycles and latches error.
        @(negedge clk);
        bus.req = 4'b0100;
        e.onehot = 4'b0100;
        e.idx = 2;
        e.due = cycle + 1;
        e.errExp = 1'b0;
        startQ.push_back(e);
        waitEngStart(ok);
        e.due = cycle + 1 + TMO;
        e.errExp = 1'b1;
        doneQ.push_back(e);
        errModel = 1'b1;
        for (int k = 0; k < TMO + 5 && doneQ.size() != 0; k++) begin
            @(negedge clk);
            #1;
        end
        bus.req = '0;
        ptrModel = 3;
        repeat (4) @(negedge clk);
        checkOutput("error_sticky", bus.error, 1);
        applyStimulus(4'b0001, 2, 1'b0, 1'b0);
        checkOutput("error_still_sticky", bus.error, 1);
        pulseReset();
`else
        checkOutput("error_tied_low", bus.error, 0);
`endif

        repeat (4) @(negedge clk);
        checkOutput("pending_starts", startQ.size(), 0);
        checkOutput("pending_dones", doneQ.size(), 0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
